io_port_unit: RTL

- Peripheral I/O stage directly downstream of the CPU core. It consumes the SRC pair value, DCL bank select, ACC and the decoder's I/O strobes.
- Implements the 4004-style ROM I/O ports (WRR/RDR) and RAM output ports (WMP).
- Returns the read nibble to the ALU operand mux on the romIoDataOut path.
- External ROM input pins are synchronised and debounced inside this block.

---
 rtl/io_port_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/io_port_unit.sv
// io_port_unit: peripheral I/O stage behind the CPU core.
//   ROM I/O ports (WRR write / RDR read) are selected by SRC[7:4].
//   RAM output ports (WMP) are selected by {bankSel[1:0], SRC[7:6]} % RAM_PORTS.
//   Each external ROM input nibble is synchronised and debounced before it
//   can be read.
// Ports:
//   clk, rstN          clock, async active-low reset
//   srcWe, srcData     one-clock strobe that loads SRC from the register pair
//   bankSel            current DCL bank (only [1:0] selects a RAM port)
//   accIn              ACC value written by WRR/WMP
//   ioWe, ioRe, ioSel  I/O write/read strobes; ioSel 0 = ROM port, 1 = RAM port
//   romPortIn          raw external pins, port k at [4k+3:4k]
//   romPortOut         ROM port output latches
//   ramPortOut         RAM port output latches
//   romIoDataOut       read nibble to the ALU mux (1-cycle latency, held)
//   portErr            one-clock pulse per access to an unimplemented ROM port

// Per-nibble input conditioner: 2-flop synchroniser plus debounce FSM.
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [3:0] pin,
    output logic [3:0] value
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {STABLE, COUNTING} state_t;

    logic [3:0]    sync1, sync2;
    logic [3:0]    deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            sync1   <= '0;
            sync2   <= '0;
            deb_q   <= '0;
            cnt_q   <= '0;
            state_q <= STABLE;
        end else begin
            sync1   <= pin;
            sync2   <= sync1;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // The counter tracks how many consecutive samples have disagreed with
    // the accepted value; any disagreeing value keeps it running, and the
    // value present at the final sample is the one accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        case (state_q)
            STABLE: begin
                if (sync2 != deb_q) begin
                    state_d = COUNTING;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            COUNTING: begin
                if (sync2 == deb_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    deb_d   = sync2;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
        endcase
    end

    assign value = deb_q;
endmodule

module io_port_unit #(
    parameter int ROM_PORTS       = 4,
    parameter int RAM_PORTS       = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic                   srcWe,
    input  logic [7:0]             srcData,
    input  logic [3:0]             bankSel,
    input  logic [3:0]             accIn,
    input  logic                   ioWe,
    input  logic                   ioRe,
    input  logic                   ioSel,
    input  logic [4*ROM_PORTS-1:0] romPortIn,
    output logic [4*ROM_PORTS-1:0] romPortOut,
    output logic [4*RAM_PORTS-1:0] ramPortOut,
    output logic [3:0]             romIoDataOut,
    output logic                   portErr
);
    localparam logic [4:0] ROM_LIM = 5'(ROM_PORTS);

    logic [7:0]                  src;
    logic [3:0]                  port_k;
    logic                        rom_hit;
    logic [3:0]                  ram_key;
    logic [31:0]                 ram_idx;
    logic [ROM_PORTS-1:0][3:0]   deb;
    logic [ROM_PORTS-1:0][3:0]   rom_q;
    logic [RAM_PORTS-1:0][3:0]   ram_q;
    logic [3:0]                  rd_val;
    logic [3:0]                  rd_q;
    logic                        err_q;
    logic                        unused_bits;

    // Accesses decode from the registered SRC, so an srcWe at the same edge
    // only affects the following access.
    assign port_k  = src[7:4];
    assign rom_hit = {1'b0, port_k} < ROM_LIM;
    assign ram_key = {bankSel[1:0], src[7:6]};
    assign ram_idx = 32'(ram_key) % RAM_PORTS;

    // Only parts of SRC and bankSel take part in port selection.
    assign unused_bits = ^{bankSel[3:2], src[3:0]};

    for (genvar g = 0; g < ROM_PORTS; g++) begin : g_in
        io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk   (clk),
            .rstN  (rstN),
            .pin   (romPortIn[4*g +: 4]),
            .value (deb[g])
        );
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < ROM_PORTS; i++) begin
            if (port_k == 4'(i)) rd_val = deb[i];
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            src   <= '0;
            rom_q <= '0;
            ram_q <= '0;
            rd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (srcWe) src <= srcData;
            if (ioWe && !ioSel && rom_hit) begin
                for (int i = 0; i < ROM_PORTS; i++) begin
                    if (port_k == 4'(i)) rom_q[i] <= accIn;
                end
            end
            if (ioWe && ioSel) begin
                for (int i = 0; i < RAM_PORTS; i++) begin
                    if (ram_idx == 32'(i)) ram_q[i] <= accIn;
                end
            end
            // Registered every clock, so each bad strobe gives exactly one
            // high cycle and back-to-back bad strobes keep it high.
            err_q <= (ioWe || ioRe) && !ioSel && !rom_hit;
            // Reserved RAM-side read and unimplemented ports both return 0.
            if (ioRe) rd_q <= (ioSel || !rom_hit) ? 4'h0 : rd_val;
        end
    end

    assign romPortOut   = rom_q;
    assign ramPortOut   = ram_q;
    assign romIoDataOut = rd_q;
    assign portErr      = err_q;
endmodule
